// File: rtl/movz_seq_encoder.sv
// movz_seq_encoder: turns a 64-bit constant plus destination register into
// the shortest MOVZ/MOVK sequence, one 32-bit word per output handshake.
// Optional macro MOVN_EN: constants dominated by 16'hFFFF halfwords start
// with MOVN instead of MOVZ.
module movz_seq_encoder #(
  parameter int         RD_W     = 5,
  parameter logic [8:0] OPC_MOVZ = 9'b110100101,
  parameter logic [8:0] OPC_MOVK = 9'b111100101,
  parameter logic [8:0] OPC_MOVN = 9'b100100101
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic [63:0]     ValueIn,
  input  logic [RD_W-1:0] RdIn,
  input  logic            InValid,
  output logic            InReady,
  output logic [31:0]     Instr,
  output logic            InstrValid,
  input  logic            InstrReady,
  output logic            InstrLast
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [63:0]     val_q, val_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [3:0]      mask_q, mask_d;   // halfwords still to be emitted
  logic            first_q, first_d; // current word is the MOVZ/MOVN head
  logic            movn_q, movn_d;   // sequence starts with MOVN

  logic [3:0]      acc_mask;
  logic            acc_movn;
  logic [1:0]      cur_hw;
  logic [15:0]     cur_half;
  logic [15:0]     cur_imm;
  logic [8:0]      cur_opc;
  logic [3:0]      rest_mask;

  function automatic logic [3:0] nz_mask(input logic [63:0] v);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (v[16*i +: 16] != 16'h0000);
    return m;
  endfunction

`ifdef MOVN_EN
  function automatic logic [3:0] ones_mask(input logic [63:0] v);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (v[16*i +: 16] == 16'hFFFF);
    return m;
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction
`endif

  // Lowest set bit; an empty mask maps to halfword 0.
  function automatic logic [1:0] low_idx(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else if (m[3]) return 2'd3;
    else           return 2'd0;
  endfunction

  function automatic logic [15:0] half_sel(input logic [63:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[15:0];
      2'd1:    return v[31:16];
      2'd2:    return v[47:32];
      default: return v[63:48];
    endcase
  endfunction

  // Classify the incoming constant: which halfwords need a word, and
  // whether the sequence head should be MOVN.
  always_comb begin
    acc_mask = nz_mask(ValueIn);
    acc_movn = 1'b0;
`ifdef MOVN_EN
    if (popcnt4(ones_mask(ValueIn)) > popcnt4(~nz_mask(ValueIn))) begin
      acc_movn = 1'b1;
      acc_mask = ~ones_mask(ValueIn);
    end
`endif
  end

  // Build the current instruction word purely from registered state so it
  // holds steady while the consumer stalls.
  always_comb begin
    cur_hw    = low_idx(mask_q);
    cur_half  = half_sel(val_q, cur_hw);
    rest_mask = mask_q & ~(4'b0001 << cur_hw);
    if (mask_q == 4'b0000)
      cur_imm = 16'h0000;
    else if (first_q && movn_q)
      cur_imm = ~cur_half;
    else
      cur_imm = cur_half;
    if (!first_q)
      cur_opc = OPC_MOVK;
    else if (movn_q)
      cur_opc = OPC_MOVN;
    else
      cur_opc = OPC_MOVZ;

    InReady    = (state_q == IDLE);
    InstrValid = (state_q == EMIT);
    InstrLast  = (state_q == EMIT) && (rest_mask == 4'b0000);
    Instr      = (state_q == EMIT) ? {cur_opc, cur_hw, cur_imm, rd_q} : 32'h0;
  end

  // Next-state: accept in IDLE, step through pending halfwords in EMIT.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rd_d    = rd_q;
    mask_d  = mask_q;
    first_d = first_q;
    movn_d  = movn_q;
    case (state_q)
      IDLE: begin
        if (InValid) begin
          state_d = EMIT;
          val_d   = ValueIn;
          rd_d    = RdIn;
          mask_d  = acc_mask;
          first_d = 1'b1;
          movn_d  = acc_movn;
        end
      end
      EMIT: begin
        if (InstrReady) begin
          mask_d  = rest_mask;
          first_d = 1'b0;
          if (rest_mask == 4'b0000) begin
            state_d = IDLE;
            movn_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any sequence in flight.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      val_q   <= '0;
      rd_q    <= '0;
      mask_q  <= '0;
      first_q <= 1'b0;
      movn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      rd_q    <= rd_d;
      mask_q  <= mask_d;
      first_q <= first_d;
      movn_q  <= movn_d;
    end
  end

endmodule

// File: tb/tb_movz_seq_encoder.sv
// Self-checking bench for movz_seq_encoder using an expected-word queue.
module tb_movz_seq_encoder;

  localparam logic [8:0] OPC_MOVZ = 9'b110100101;
  localparam logic [8:0] OPC_MOVK = 9'b111100101;
  localparam logic [8:0] OPC_MOVN = 9'b100100101;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic [63:0] ValueIn;
  logic [4:0]  RdIn;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InstrReady;
  logic        InstrLast;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];     // {last, instr}
  int          rdy_mode = 0; // 0: always ready, 1: 3-cycle stall per word, 2: random
  logic        stalled_prev = 1'b0;

  always #5 CLK = ~CLK;

  movz_seq_encoder dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .ValueIn    (ValueIn),
    .RdIn       (RdIn),
    .InValid    (InValid),
    .InReady    (InReady),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .InstrLast  (InstrLast)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic last);
    exp_q.push_back({last, w});
  endtask

  // Reference model for arbitrary constants.
  task automatic push_model(input logic [63:0] v, input logic [4:0] rd);
    logic [15:0] h[4];
    int          z = 0;
    int          f = 0;
    bit          neg = 0;
    bit          first = 1;
    logic [3:0]  m;
    logic [8:0]  opc;
    logic [15:0] imm;
    for (int i = 0; i < 4; i++) begin
      h[i] = v[16*i +: 16];
      if (h[i] == 16'h0000) z++;
      if (h[i] == 16'hFFFF) f++;
    end
`ifdef MOVN_EN
    neg = (f > z);
`endif
    for (int i = 0; i < 4; i++) m[i] = neg ? (h[i] != 16'hFFFF) : (h[i] != 16'h0000);
    if (m == 4'b0000) begin
      push({neg ? OPC_MOVN : OPC_MOVZ, 2'b00, 16'h0000, rd}, 1'b1);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          opc = first ? (neg ? OPC_MOVN : OPC_MOVZ) : OPC_MOVK;
          imm = (first && neg) ? ~h[i] : h[i];
          push({opc, 2'(i), imm, rd}, (m >> (i + 1)) == 4'b0000);
          first = 0;
        end
      end
    end
  endtask

  task automatic send(input logic [63:0] v, input logic [4:0] rd);
    int n = 0;
    ValueIn = v;
    RdIn    = rd;
    InValid = 1'b1;
    while (!InReady && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    check("accept_wait", {63'h0, InReady}, 64'h1);
    @(posedge CLK); #1;
    InValid = 1'b0;
    check("busy_after_accept", {63'h0, InReady}, 64'h0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !InReady) && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'h0);
    check("drain_ready", {63'h0, InReady}, 64'h1);
  endtask

  // Consumer ready driver.
  initial begin
    int cnt = 0;
    InstrReady = 1'b1;
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        1: begin
          if (InstrValid && cnt < 3) begin
            InstrReady = 1'b0;
            cnt++;
          end else begin
            InstrReady = 1'b1;
            cnt = 0;
          end
        end
        2: InstrReady = 1'($urandom_range(0, 1));
        default: begin
          InstrReady = 1'b1;
          cnt = 0;
        end
      endcase
    end
  end

  // Output monitor: compare each visible word against the queue head,
  // pop on the handshake that the coming edge will complete.
  initial begin
    logic [32:0] popped;
    forever begin
      @(negedge CLK);
      if (Reset_n) begin
        if (stalled_prev) check("valid_hold", {63'h0, InstrValid}, 64'h1);
        stalled_prev = InstrValid && !InstrReady;
        if (InstrValid) begin
          if (exp_q.size() == 0) begin
            check("extra_word", {63'h0, InstrValid}, 64'h0);
          end else begin
            check("instr", {32'h0, Instr}, {32'h0, exp_q[0][31:0]});
            check("last", {63'h0, InstrLast}, {63'h0, exp_q[0][32]});
            if (InstrReady) popped = exp_q.pop_front();
          end
        end
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] v;
    Reset_n = 1'b0;
    InValid = 1'b0;
    ValueIn = '0;
    RdIn    = '0;
    #12;
    check("rst_inready", {63'h0, InReady}, 64'h1);
    check("rst_valid", {63'h0, InstrValid}, 64'h0);
    check("rst_last", {63'h0, InstrLast}, 64'h0);
    check("rst_instr", {32'h0, Instr}, 64'h0);
    @(negedge CLK);
    Reset_n = 1'b1;
    @(posedge CLK); #1;

    // Zero constant
    push(32'hD2800001, 1'b1);
    send(64'h0, 5'd1);
    @(posedge CLK); #1;
    check("t1_ready_back", {63'h0, InReady}, 64'h1);
    check("t1_valid_gone", {63'h0, InstrValid}, 64'h0);
    drain();

    // Sparse constant
    push(32'hD28ACF02, 1'b0);
    push(32'hF2C24682, 1'b1);
    send(64'h0000_1234_0000_5678, 5'd2);
    drain();

    // Top halfword only
    push(32'hD2F579A3, 1'b1);
    send(64'hABCD_0000_0000_0000, 5'd3);
    drain();

    // Backpressure with ignored InValid during EMIT
    rdy_mode = 1;
    push(32'hD28ACF02, 1'b0);
    push(32'hF2C24682, 1'b1);
    send(64'h0000_1234_0000_5678, 5'd2);
    ValueIn = 64'hDEAD_BEEF_0000_0001;
    RdIn    = 5'd9;
    InValid = 1'b1;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    InValid = 1'b0;
    drain();
    rdy_mode = 0;

    // Dense constant
`ifdef MOVN_EN
    push(32'h92800024, 1'b1);
`else
    push(32'hD29FFFC4, 1'b0);
    push(32'hF2BFFFE4, 1'b0);
    push(32'hF2DFFFE4, 1'b0);
    push(32'hF2FFFFE4, 1'b1);
`endif
    send(64'hFFFF_FFFF_FFFF_FFFE, 5'd4);
    drain();

    // Reset mid-sequence
    push(32'hD28ACF02, 1'b0);
    push(32'hF2C24682, 1'b1);
    send(64'h0000_1234_0000_5678, 5'd2);
    @(posedge CLK); #1;
    Reset_n = 1'b0;
    #1;
    check("midrst_valid", {63'h0, InstrValid}, 64'h0);
    check("midrst_inready", {63'h0, InReady}, 64'h1);
    check("midrst_last", {63'h0, InstrLast}, 64'h0);
    check("midrst_instr", {32'h0, Instr}, 64'h0);
    exp_q.delete();
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
    @(posedge CLK); #1;
    push(32'hD2800001, 1'b1);
    send(64'h0, 5'd1);
    drain();

    // Mixed constants through the model, random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 2))
          0:       v[16*i +: 16] = 16'h0000;
          1:       v[16*i +: 16] = 16'hFFFF;
          default: v[16*i +: 16] = 16'($urandom);
        endcase
      end
      push_model(v, 5'($urandom_range(0, 31)));
      send(v, exp_q[0][4:0]);
      drain();
    end
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
